fifo_flex: RTL and testbench
============================

// Module: fifo_flex
// PURPOSE
//  Synchronous single-clock FIFO, successor to the fixed 4-entry byte FIFO.
//  Adds parametrised data width and depth (non-power-of-two depth allowed).
//  Adds programmable almost-full/almost-empty thresholds, an occupancy count
//  and sticky overflow/underflow flags. Used as the generic buffer between
//  producer/consumer blocks in the design.
// PARAMETERS
//  WIDTH      8  data width in bits (>=1)
//  DEPTH      4  number of entries (>=2, any integer)
//  AF_THRESH  3  out_almost_full asserts when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH  1  out_almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//  clk               in   1                 rising-edge clock
//  rst               in   1                 asynchronous, active-high reset
//  in_write_ctrl     in   1                 write request
//  in_write_data     in   WIDTH             write data
//  in_read_ctrl      in   1                 read request
//  in_clear_err      in   1                 synchronous clear of sticky errors
//  out_read_data     out  WIDTH             registered read data
//  out_read_valid    out  1                 out_read_data updated this cycle
//  out_count         out  $clog2(DEPTH+1)   current occupancy
//  out_is_full       out  1                 count == DEPTH
//  out_is_empty      out  1                 count == 0
//  out_almost_full   out  1                 count >= AF_THRESH
//  out_almost_empty  out  1                 count <= AE_THRESH
//  out_overflow      out  1                 sticky: write dropped
//  out_underflow     out  1                 sticky: read rejected
// BEHAVIOUR
//  - Reset (async, active-high): pointers=0, count=0, out_is_empty=1,
//    out_almost_empty=1, out_is_full=0, out_almost_full=0,
//    out_read_data=0, out_read_valid=0, out_overflow=0, out_underflow=0.
//    Storage contents are not reset. Reset asserted mid-operation discards
//    all entries immediately.
//  - rd_acc = in_read_ctrl & ~out_is_empty.
//  - wr_acc = in_write_ctrl & (~out_is_full | in_read_ctrl).
//    A write while full is accepted only with a simultaneous read.
//  - Empty + simultaneous read/write: the read is rejected (no bypass) and
//    sets underflow. The write is accepted.
//  - rd_acc: the head entry appears on out_read_data at the next edge
//    (1-cycle latency). out_read_valid is high for exactly that one cycle.
//    Otherwise out_read_data holds its last value and out_read_valid=0.
//  - Pointers advance by 1 on accept and wrap DEPTH-1 -> 0 explicitly.
//    Wrap must not rely on power-of-two truncation.
//  - count_next = count + wr_acc - rd_acc (both accepted -> unchanged).
//    All status flags are registered, computed from count_next, and always
//    consistent with out_count in the same cycle.
//  - Overflow: in_write_ctrl & ~wr_acc sets out_overflow; the data is dropped.
//  - Underflow: in_read_ctrl & ~rd_acc sets out_underflow; pointer unchanged.
//  - in_clear_err clears both sticky flags; a set event in the same cycle wins.
//  - Elaboration check ($error) on illegal DEPTH, AF_THRESH or AE_THRESH.
// STRUCTURE
//  - Package fifo_flex_pkg:
//    * function cnt_w(depth) = $clog2(depth+1)
//    * function ptr_w(depth) = max(1,$clog2(depth))
//    * typedef fifo_status_t {full, empty, almost_full, almost_empty}
//  - Sub-module fifo_wrap_ptr: parametrised (DEPTH) modulo-DEPTH pointer
//    with inc input; instantiated twice (read, write).
//  - Storage is an unpacked array of WIDTH-bit words, written on wr_acc.
// TESTING  (WIDTH=8, DEPTH=5, AF_THRESH=4, AE_THRESH=1 unless noted)
//  1 Fill: 5 writes 0x11..0x55 -> count 1..5; almost_empty drops at count 2;
//    almost_full rises at count 4; full at 5; 6th write -> overflow=1, count=5.
//  2 Drain: 5 reads -> data 0x11..0x55, each 1 cycle after its read, valid
//    pulses 5x; empty at count 0; 6th read -> underflow=1, valid=0.
//  3 Wrap: 3 writes, 3 reads, then 4 writes/4 reads (pointers cross 4->0)
//    -> data order preserved, no errors.
//  4 Simultaneous: full + rd&wr -> count stays 5, no overflow; empty + rd&wr
//    -> count 1, underflow=1, the written word is read back next.
//  5 Errors: overflow set, in_clear_err with another overflow same cycle ->
//    stays 1; clear alone -> 0 next cycle.
//  6 Reset mid-stream: count=3, assert rst between edges -> count=0, empty=1,
//    valid=0 immediately; next write/read returns the new word only.

Source files
------------

// File: rtl/fifo_flex_pkg.sv
// Shared types and width helpers for the flexible single-clock FIFO.
//   cnt_w(depth)  : bits needed to hold an occupancy of 0..depth
//   ptr_w(depth)  : bits needed to address depth entries (at least 1)
//   fifo_status_t : registered status flag bundle
package fifo_flex_pkg;

    // Occupancy counter width: must represent the value DEPTH itself.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width: never zero, even for tiny depths.
    function automatic int unsigned ptr_w(input int unsigned depth);
        int unsigned w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage : fifo_flex_pkg

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer that advances by one on inc_i.
//   clk, rst : clock, asynchronous active-high reset (pointer -> 0)
//   inc_i    : advance request
//   ptr_o    : current pointer value, always in 0..DEPTH-1
module fifo_wrap_ptr
    import fifo_flex_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inc_i,
    output logic [ptr_w(DEPTH)-1:0]   ptr_o
);

    localparam int unsigned PW   = ptr_w(DEPTH);
    localparam int unsigned LAST = DEPTH - 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            if (ptr_q == PW'(LAST)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule : fifo_wrap_ptr

// File: rtl/fifo_flex.sv
// Single-clock FIFO with parametrised width/depth, programmable almost
// thresholds, occupancy count and sticky overflow/underflow flags.
//   clk, rst          : clock, asynchronous active-high reset
//   in_write_ctrl     : write request, data on in_write_data
//   in_read_ctrl      : read request, head appears on out_read_data next cycle
//   in_clear_err      : clears sticky error flags (a same-cycle set wins)
//   out_read_data     : registered read data, holds between reads
//   out_read_valid    : one-cycle pulse when out_read_data was updated
//   out_count         : occupancy
//   out_is_full/out_is_empty/out_almost_full/out_almost_empty : status
//   out_overflow      : sticky, a write was dropped
//   out_underflow     : sticky, a read was rejected
module fifo_flex
    import fifo_flex_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AF_THRESH = 3,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_write_ctrl,
    input  logic [WIDTH-1:0]          in_write_data,
    input  logic                      in_read_ctrl,
    input  logic                      in_clear_err,
    output logic [WIDTH-1:0]          out_read_data,
    output logic                      out_read_valid,
    output logic [cnt_w(DEPTH)-1:0]   out_count,
    output logic                      out_is_full,
    output logic                      out_is_empty,
    output logic                      out_almost_full,
    output logic                      out_almost_empty,
    output logic                      out_overflow,
    output logic                      out_underflow
);

    localparam int unsigned CW = cnt_w(DEPTH);
    localparam int unsigned PW = ptr_w(DEPTH);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 1) begin : g_bad_width
        $error("fifo_flex: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_flex: DEPTH must be >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $error("fifo_flex: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("fifo_flex: AE_THRESH must be in 0..DEPTH-1");
    end

    localparam fifo_status_t STATUS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    fifo_status_t       status_q;
    fifo_status_t       status_d;
    logic [WIDTH-1:0]   rd_data_q;
    logic [WIDTH-1:0]   rd_data_d;
    logic               rd_valid_q;
    logic               rd_valid_d;
    logic               ovf_q;
    logic               ovf_d;
    logic               udf_q;
    logic               udf_d;

    logic               rd_acc;
    logic               wr_acc;

    // Acceptance: no read bypass on empty; a full FIFO takes a write only
    // alongside a read, which frees the head slot at the same edge.
    assign rd_acc = in_read_ctrl & ~status_q.empty;
    assign wr_acc = in_write_ctrl & (~status_q.full | in_read_ctrl);

    fifo_wrap_ptr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (wr_acc),
        .ptr_o (wr_ptr)
    );

    fifo_wrap_ptr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (rd_acc),
        .ptr_o (rd_ptr)
    );

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr] <= in_write_data;
        end
    end

    // Next occupancy, status derived from it so flags track out_count.
    always_comb begin
        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end

        status_d              = STATUS_RST;
        status_d.full         = (count_d == CW'(DEPTH));
        status_d.empty        = (count_d == '0);
        status_d.almost_full  = (count_d >= CW'(AF_THRESH));
        status_d.almost_empty = (count_d <= CW'(AE_THRESH));
    end

    // Read data path and sticky errors; a set event beats a clear.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc;
        if (rd_acc) begin
            rd_data_d = mem_q[rd_ptr];
        end

        ovf_d = ovf_q & ~in_clear_err;
        udf_d = udf_q & ~in_clear_err;
        if (in_write_ctrl && !wr_acc) begin
            ovf_d = 1'b1;
        end
        if (in_read_ctrl && !rd_acc) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            status_q   <= STATUS_RST;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            status_q   <= status_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign out_read_data    = rd_data_q;
    assign out_read_valid   = rd_valid_q;
    assign out_count        = count_q;
    assign out_is_full      = status_q.full;
    assign out_is_empty     = status_q.empty;
    assign out_almost_full  = status_q.almost_full;
    assign out_almost_empty = status_q.almost_empty;
    assign out_overflow     = ovf_q;
    assign out_underflow    = udf_q;

endmodule : fifo_flex

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex (WIDTH=8, DEPTH=5, AF_THRESH=4, AE_THRESH=1).
module tb_fifo_flex;

    logic       clk;
    logic       rst;
    logic       in_write_ctrl;
    logic [7:0] in_write_data;
    logic       in_read_ctrl;
    logic       in_clear_err;
    logic [7:0] out_read_data;
    logic       out_read_valid;
    logic [2:0] out_count;
    logic       out_is_full;
    logic       out_is_empty;
    logic       out_almost_full;
    logic       out_almost_empty;
    logic       out_overflow;
    logic       out_underflow;

    int total;
    int bad;

    fifo_flex #(
        .WIDTH     (8),
        .DEPTH     (5),
        .AF_THRESH (4),
        .AE_THRESH (1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_write_ctrl    (in_write_ctrl),
        .in_write_data    (in_write_data),
        .in_read_ctrl     (in_read_ctrl),
        .in_clear_err     (in_clear_err),
        .out_read_data    (out_read_data),
        .out_read_valid   (out_read_valid),
        .out_count        (out_count),
        .out_is_full      (out_is_full),
        .out_is_empty     (out_is_empty),
        .out_almost_full  (out_almost_full),
        .out_almost_empty (out_almost_empty),
        .out_overflow     (out_overflow),
        .out_underflow    (out_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs for one cycle and the outputs expected after its edge.
    // fl = {full, empty, almost_full, almost_empty}
    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic       clr;
        int         cnt;
        logic [3:0] fl;
        logic       ovf;
        logic       udf;
        logic       vld;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic wr, input logic [7:0] wd,
                                input logic rd, input logic clr,
                                input int cnt, input logic [3:0] fl,
                                input logic ovf, input logic udf,
                                input logic vld, input logic [7:0] data);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rd = rd; v.clr = clr;
        v.cnt = cnt; v.fl = fl; v.ovf = ovf; v.udf = udf;
        v.vld = vld; v.data = data;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d actual=0x%0h required=0x%0h",
                     name, row, act, exp);
        end
    endtask

    task automatic chk_all(input int row, input int cnt, input logic [3:0] fl,
                           input logic ovf, input logic udf,
                           input logic vld, input logic [7:0] data);
        chk("count", row, 32'(out_count), 32'(cnt));
        chk("flags", row,
            32'({out_is_full, out_is_empty, out_almost_full, out_almost_empty}),
            32'(fl));
        chk("overflow", row, 32'(out_overflow), 32'(ovf));
        chk("underflow", row, 32'(out_underflow), 32'(udf));
        chk("valid", row, 32'(out_read_valid), 32'(vld));
        chk("data", row, 32'(out_read_data), 32'(data));
    endtask

    task automatic drive(input logic wr, input logic [7:0] wd,
                         input logic rd, input logic clr);
        @(negedge clk);
        in_write_ctrl = wr;
        in_write_data = wd;
        in_read_ctrl  = rd;
        in_clear_err  = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        in_write_ctrl = 1'b0;
        in_write_data = 8'h00;
        in_read_ctrl  = 1'b0;
        in_clear_err  = 1'b0;

        // Fill
        add(1, 8'h11, 0, 0, 1, 4'b0001, 0, 0, 0, 8'h00);
        add(1, 8'h22, 0, 0, 2, 4'b0000, 0, 0, 0, 8'h00);
        add(1, 8'h33, 0, 0, 3, 4'b0000, 0, 0, 0, 8'h00);
        add(1, 8'h44, 0, 0, 4, 4'b0010, 0, 0, 0, 8'h00);
        add(1, 8'h55, 0, 0, 5, 4'b1010, 0, 0, 0, 8'h00);
        add(1, 8'h66, 0, 0, 5, 4'b1010, 1, 0, 0, 8'h00);
        // Drain, then underflow
        add(0, 8'h00, 1, 0, 4, 4'b0010, 1, 0, 1, 8'h11);
        add(0, 8'h00, 1, 0, 3, 4'b0000, 1, 0, 1, 8'h22);
        add(0, 8'h00, 1, 0, 2, 4'b0000, 1, 0, 1, 8'h33);
        add(0, 8'h00, 1, 0, 1, 4'b0001, 1, 0, 1, 8'h44);
        add(0, 8'h00, 1, 0, 0, 4'b0101, 1, 0, 1, 8'h55);
        add(0, 8'h00, 1, 0, 0, 4'b0101, 1, 1, 0, 8'h55);
        add(0, 8'h00, 0, 1, 0, 4'b0101, 0, 0, 0, 8'h55);
        // Wrap: 3 in/out, then 4 in/out across the 4->0 boundary
        add(1, 8'hA1, 0, 0, 1, 4'b0001, 0, 0, 0, 8'h55);
        add(1, 8'hA2, 0, 0, 2, 4'b0000, 0, 0, 0, 8'h55);
        add(1, 8'hA3, 0, 0, 3, 4'b0000, 0, 0, 0, 8'h55);
        add(0, 8'h00, 1, 0, 2, 4'b0000, 0, 0, 1, 8'hA1);
        add(0, 8'h00, 1, 0, 1, 4'b0001, 0, 0, 1, 8'hA2);
        add(0, 8'h00, 1, 0, 0, 4'b0101, 0, 0, 1, 8'hA3);
        add(1, 8'hB1, 0, 0, 1, 4'b0001, 0, 0, 0, 8'hA3);
        add(1, 8'hB2, 0, 0, 2, 4'b0000, 0, 0, 0, 8'hA3);
        add(1, 8'hB3, 0, 0, 3, 4'b0000, 0, 0, 0, 8'hA3);
        add(1, 8'hB4, 0, 0, 4, 4'b0010, 0, 0, 0, 8'hA3);
        add(0, 8'h00, 1, 0, 3, 4'b0000, 0, 0, 1, 8'hB1);
        add(0, 8'h00, 1, 0, 2, 4'b0000, 0, 0, 1, 8'hB2);
        add(0, 8'h00, 1, 0, 1, 4'b0001, 0, 0, 1, 8'hB3);
        add(0, 8'h00, 1, 0, 0, 4'b0101, 0, 0, 1, 8'hB4);
        // Full + simultaneous read/write
        add(1, 8'hC1, 0, 0, 1, 4'b0001, 0, 0, 0, 8'hB4);
        add(1, 8'hC2, 0, 0, 2, 4'b0000, 0, 0, 0, 8'hB4);
        add(1, 8'hC3, 0, 0, 3, 4'b0000, 0, 0, 0, 8'hB4);
        add(1, 8'hC4, 0, 0, 4, 4'b0010, 0, 0, 0, 8'hB4);
        add(1, 8'hC5, 0, 0, 5, 4'b1010, 0, 0, 0, 8'hB4);
        add(1, 8'hD1, 1, 0, 5, 4'b1010, 0, 0, 1, 8'hC1);
        add(0, 8'h00, 1, 0, 4, 4'b0010, 0, 0, 1, 8'hC2);
        add(0, 8'h00, 1, 0, 3, 4'b0000, 0, 0, 1, 8'hC3);
        add(0, 8'h00, 1, 0, 2, 4'b0000, 0, 0, 1, 8'hC4);
        add(0, 8'h00, 1, 0, 1, 4'b0001, 0, 0, 1, 8'hC5);
        add(0, 8'h00, 1, 0, 0, 4'b0101, 0, 0, 1, 8'hD1);
        // Empty + simultaneous read/write: read rejected, write kept
        add(1, 8'hE1, 1, 0, 1, 4'b0001, 0, 1, 0, 8'hD1);
        add(0, 8'h00, 1, 0, 0, 4'b0101, 0, 1, 1, 8'hE1);
        add(0, 8'h00, 0, 1, 0, 4'b0101, 0, 0, 0, 8'hE1);
        // Error flag set/clear priority
        add(1, 8'hF1, 0, 0, 1, 4'b0001, 0, 0, 0, 8'hE1);
        add(1, 8'hF2, 0, 0, 2, 4'b0000, 0, 0, 0, 8'hE1);
        add(1, 8'hF3, 0, 0, 3, 4'b0000, 0, 0, 0, 8'hE1);
        add(1, 8'hF4, 0, 0, 4, 4'b0010, 0, 0, 0, 8'hE1);
        add(1, 8'hF5, 0, 0, 5, 4'b1010, 0, 0, 0, 8'hE1);
        add(1, 8'hF6, 0, 0, 5, 4'b1010, 1, 0, 0, 8'hE1);
        add(1, 8'hF7, 0, 1, 5, 4'b1010, 1, 0, 0, 8'hE1);
        add(0, 8'h00, 0, 1, 5, 4'b1010, 0, 0, 0, 8'hE1);
        add(0, 8'h00, 1, 0, 4, 4'b0010, 0, 0, 1, 8'hF1);
        add(0, 8'h00, 1, 0, 3, 4'b0000, 0, 0, 1, 8'hF2);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_all(-1, 0, 4'b0101, 0, 0, 0, 8'h00);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
            chk_all(i, vecs[i].cnt, vecs[i].fl, vecs[i].ovf, vecs[i].udf,
                    vecs[i].vld, vecs[i].data);
        end

        // Reset mid-stream (count 3, valid high): effect is immediate
        @(negedge clk);
        in_write_ctrl = 1'b0;
        in_read_ctrl  = 1'b0;
        in_clear_err  = 1'b0;
        rst = 1'b1;
        #1;
        chk_all(100, 0, 4'b0101, 0, 0, 0, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Only the freshly written word comes back afterwards
        drive(1, 8'h77, 0, 0);
        chk_all(101, 1, 4'b0001, 0, 0, 0, 8'h00);
        drive(0, 8'h00, 1, 0);
        chk_all(102, 0, 4'b0101, 0, 0, 1, 8'h77);
        drive(0, 8'h00, 1, 0);
        chk_all(103, 0, 4'b0101, 0, 1, 0, 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fifo_flex
